// File: rtl/chain_latency_ctrl.sv
// Self-test sequencer for a same-clock register chain: flushes it, launches a
// rising then a falling step, measures both latencies and reports the verdict.
module chain_latency_ctrl #(
  parameter int N_EXP   = 256,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             stuck_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lat_rise,
  output logic [CNT_W-1:0] lat_fall,
  output logic [7:0]       leds
);

  typedef enum logic [2:0] {IDLE, FLUSH, RISE_WAIT, FALL_WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAT_EXP   = CNT_W'(N_EXP);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lat_rise_n, lat_fall_n;
  logic             chain_in_n, pass_n, stuck_n, timeout_n;
  logic             mismatch;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      chain_in    <= 1'b0;
      pass        <= 1'b0;
      stuck_err   <= 1'b0;
      timeout_err <= 1'b0;
      lat_rise    <= '0;
      lat_fall    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      chain_in    <= chain_in_n;
      pass        <= pass_n;
      stuck_err   <= stuck_n;
      timeout_err <= timeout_n;
      lat_rise    <= lat_rise_n;
      lat_fall    <= lat_fall_n;
    end
  end

  // NOTE: every signal driven here gets a hold default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    chain_in_n = chain_in;
    pass_n     = pass;
    stuck_n    = stuck_err;
    timeout_n  = timeout_err;
    lat_rise_n = lat_rise;
    lat_fall_n = lat_fall;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = FLUSH;
          cnt_n      = '0;
          chain_in_n = 1'b0;
          pass_n     = 1'b0;
          stuck_n    = 1'b0;
          timeout_n  = 1'b0;
          lat_rise_n = '0;
          lat_fall_n = '0;
        end
      end

      FLUSH: begin
        chain_in_n = 1'b0;
        if (cnt == CNT_LIMIT) begin
          if (chain_out) begin
            stuck_n = 1'b1;
            state_n = DONE;
          end else begin
            state_n    = RISE_WAIT;
            chain_in_n = 1'b1;
            cnt_n      = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // The limit check precedes the increment, so cnt never wraps.
      RISE_WAIT: begin
        if (chain_out) begin
          lat_rise_n = cnt;
          chain_in_n = 1'b0;
          cnt_n      = '0;
          state_n    = FALL_WAIT;
        end else if (cnt == CNT_LIMIT) begin
          timeout_n  = 1'b1;
          lat_rise_n = '1;
          chain_in_n = 1'b0;
          state_n    = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      FALL_WAIT: begin
        chain_in_n = 1'b0;
        if (!chain_out) begin
          lat_fall_n = cnt;
          state_n    = DONE;
        end else if (cnt == CNT_LIMIT) begin
          timeout_n  = 1'b1;
          lat_fall_n = '1;
          state_n    = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n    = IDLE;
        chain_in_n = 1'b0;
      end
    endcase

    // Verdict is formed from the values being registered on the DONE entry
    // edge, so pass is already valid in the first DONE cycle.
    if (state != DONE && state_n == DONE) begin
      pass_n = !stuck_n && !timeout_n &&
               (lat_rise_n == LAT_EXP) && (lat_fall_n == LAT_EXP);
    end
  end

  assign busy     = (state == FLUSH) || (state == RISE_WAIT) || (state == FALL_WAIT);
  assign done     = (state == DONE);
  assign mismatch = !stuck_err && !timeout_err && !pass;

  always_comb begin
    leds = 8'h00;
    if (done) begin
      if (pass) leds = lat_rise[7:0];
      else      leds = {5'b11111, stuck_err, timeout_err, mismatch};
    end
  end

endmodule
